vec_uart_loader: RTL
====================

Name: vec_uart_loader

Overview:
- Upstream loader for the vector-processing datapath.
- Accepts a command byte followed by N_ELEM payload bytes from the UART receiver.
- Writes each payload byte into vector BRAM A or B at consecutive addresses.
- Pulses load_done when the vector is complete. Aborts cleanly on bad command or inter-byte timeout.

Parameters:
- N_ELEM, 1024, elements per vector.
- ADDR_W, 10, BRAM address width; must satisfy 2**ADDR_W >= N_ELEM.
- DATA_W, 8, element width, equal to the UART byte width.
- TIMEOUT_CYC, 1_000_000, maximum idle cycles between payload bytes before abort.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received UART byte, valid only while rx_valid=1
- rx_valid  in  1  one-cycle strobe, one byte per strobe
- busy  out  1  high while in LOAD
- wr_en_a  out  1  BRAM A write strobe
- wr_en_b  out  1  BRAM B write strobe
- wr_addr  out  ADDR_W  write address
- wr_data  out  DATA_W  write data
- load_done  out  1  one-cycle pulse, full vector written
- cmd_err  out  1  one-cycle pulse, unknown command byte
- abort  out  1  one-cycle pulse, timeout during LOAD

Behaviour:
- Clock and reset: clk drives all state. reset is synchronous, active-high, clock clk.
- Reset values: all outputs are registered and reset to 0. State=IDLE, element counter=0, timeout counter=0, target=A.
- FSM states: IDLE, LOAD.
- IDLE, rx_valid with rx_data=CMD_WRITE_A (8'h01) or CMD_WRITE_B (8'h02):
  - latch target, clear element counter and timeout counter, go to LOAD.
  - busy=1 from the next cycle.
- IDLE, rx_valid with any other byte: cmd_err=1 on the next cycle, stay in IDLE, no write.
- LOAD, rx_valid: on the next cycle
  - wr_en_<target>=1 for exactly one cycle;
  - wr_addr = element count before increment; wr_data = rx_data;
  - counter increments, timeout counter clears.
- Last element (count = N_ELEM-1):
  - load_done=1 in the same cycle as the final write strobe;
  - state returns to IDLE, so busy=0 in that same cycle.
- Timeout: in LOAD with no rx_valid, the timeout counter increments each cycle.
  - When it reaches TIMEOUT_CYC-1: abort=1 next cycle, return to IDLE.
  - The counter is not cleared; BRAM keeps the partial data.
- rx_valid in the same cycle the timeout would expire: the byte wins; it is written and the timeout counter clears.
- Back-to-back rx_valid on every cycle is sustained with no drops (throughput 1 byte/cycle).
- Write enables: never both high; both low outside LOAD.
- Width rules:
  - Element counter is $clog2(N_ELEM+1) bits, compared against N_ELEM-1 exactly.
  - Timeout counter is $clog2(TIMEOUT_CYC) bits and saturates at expiry, never wraps.
- Reset mid-LOAD: immediate return to IDLE at that edge; all pulses and strobes 0. The next command restarts at address 0.
- Command bytes in LOAD: treated as payload, not reinterpreted.

Decomposition:
- Package vec_pkg: CMD_WRITE_A and CMD_WRITE_B localparams, loader_state_t enum {IDLE, LOAD}, vec_sel_t enum {VEC_A, VEC_B}.
- Sub-module elem_addr_counter (params N, MAX_COUNT; ports clk, reset, clear, inc, count, last):
  - clear has priority over inc;
  - last is combinational (count==MAX_COUNT-1).
- Top module holds the FSM, timeout counter and output registers.

Test Plan:
- Normal load A: reset, send 0x01, then 1024 bytes with value i%256, one every 16 cycles.
  - Expect 1024 wr_en_a pulses, wr_addr 0..1023, wr_data=i%256, wr_en_b never high.
  - Expect load_done coincident with the addr=1023 write, busy=0 afterwards.
- Bad command: send 0x7F in IDLE.
  - Expect cmd_err=1 exactly one cycle after rx_valid, no write strobes, busy stays 0.
- Timeout abort: with TIMEOUT_CYC=50, send 0x02, then 10 bytes, then silence.
  - Expect abort pulse 50 cycles after the last byte and busy=0.
  - A new 0x02 plus one byte then writes wr_addr=0 on wr_en_b.
- Reset mid-load: send 0x01 and 500 bytes, then assert reset for 1 cycle.
  - Expect all outputs 0 at the next edge.
  - A following full load starts at addr 0 and completes with load_done.
- Streaming plus race: N_ELEM=8, rx_valid high on 8 consecutive cycles after 0x01.
  - Expect 8 consecutive write strobes with no gaps.
  - Separately, a byte arriving on the timeout-expiry cycle is written and no abort is issued.

Source files
------------

// File: rtl/vec_uart_loader_pkg.sv
// vec_pkg: shared definitions for the UART vector loader.
//   CMD_WRITE_A / CMD_WRITE_B : command bytes selecting the destination BRAM
//   loader_state_t            : loader FSM states
//   vec_sel_t                 : destination vector select
package vec_pkg;

   localparam logic [7:0] CMD_WRITE_A = 8'h01;
   localparam logic [7:0] CMD_WRITE_B = 8'h02;

   typedef enum logic {IDLE, LOAD} loader_state_t;
   typedef enum logic {VEC_A, VEC_B} vec_sel_t;

endpackage

// File: rtl/vec_uart_loader_elem_addr_counter.sv
// elem_addr_counter: element index counter for the vector loader.
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the counter (wins over inc)
//   inc        : advance by one
//   count      : current element index (N bits)
//   last       : combinational, high when count == MAX_COUNT-1
module elem_addr_counter
   import vec_pkg::*;
#(
   parameter int N         = 11,
   parameter int MAX_COUNT = 1024
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         inc,
   output logic [N-1:0] count,
   output logic         last
);

   always_ff @(posedge clk) begin
      if (reset || clear)
         count <= '0;
      else if (inc)
         count <= count + N'(1);
   end

   assign last = (count == N'(MAX_COUNT - 1));

endmodule

// File: rtl/vec_uart_loader.sv
// vec_uart_loader: takes a command byte (0x01 -> vector A, 0x02 -> vector B)
// followed by N_ELEM payload bytes and writes them to consecutive BRAM
// addresses. Unknown commands pulse cmd_err; a gap of TIMEOUT_CYC idle cycles
// during a load pulses abort and drops back to IDLE (partial data stays).
//   clk, reset         : clock, synchronous active-high reset
//   rx_data, rx_valid  : byte stream from the UART receiver
//   busy               : high while a vector load is in progress
//   wr_en_a, wr_en_b   : BRAM A / B write strobes
//   wr_addr, wr_data   : write address / data
//   load_done          : pulse with the final element write
//   cmd_err            : pulse on an unknown command byte
//   abort              : pulse on inter-byte timeout
// All outputs are registered.
module vec_uart_loader
   import vec_pkg::*;
#(
   parameter int N_ELEM      = 1024,
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic              busy,
   output logic              wr_en_a,
   output logic              wr_en_b,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              load_done,
   output logic              cmd_err,
   output logic              abort
);

   localparam int CNT_W = $clog2(N_ELEM + 1);
   localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   loader_state_t    state;
   vec_sel_t         target;
   logic [TMO_W-1:0] tmo_cnt;
   logic [CNT_W-1:0] elem_cnt;
   logic             elem_last;
   logic             is_cmd_a, is_cmd_b;
   logic             cnt_clear, cnt_inc;

   assign is_cmd_a  = (rx_data == DATA_W'(CMD_WRITE_A));
   assign is_cmd_b  = (rx_data == DATA_W'(CMD_WRITE_B));
   assign cnt_clear = (state == IDLE) && rx_valid && (is_cmd_a || is_cmd_b);
   assign cnt_inc   = (state == LOAD) && rx_valid;

   elem_addr_counter #(
      .N         (CNT_W),
      .MAX_COUNT (N_ELEM)
   ) u_elem_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (cnt_clear),
      .inc   (cnt_inc),
      .count (elem_cnt),
      .last  (elem_last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         target    <= VEC_A;
         tmo_cnt   <= '0;
         busy      <= 1'b0;
         wr_en_a   <= 1'b0;
         wr_en_b   <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         load_done <= 1'b0;
         cmd_err   <= 1'b0;
         abort     <= 1'b0;
      end else begin
         // pulses default low; address/data hold their last write
         wr_en_a   <= 1'b0;
         wr_en_b   <= 1'b0;
         load_done <= 1'b0;
         cmd_err   <= 1'b0;
         abort     <= 1'b0;
         case (state)
            IDLE: begin
               if (rx_valid) begin
                  if (is_cmd_a || is_cmd_b) begin
                     target  <= is_cmd_b ? VEC_B : VEC_A;
                     tmo_cnt <= '0;
                     state   <= LOAD;
                     busy    <= 1'b1;
                  end else begin
                     cmd_err <= 1'b1;
                  end
               end
            end
            LOAD: begin
               // an arriving byte beats a timeout expiring in the same cycle
               if (rx_valid) begin
                  wr_en_a <= (target == VEC_A);
                  wr_en_b <= (target == VEC_B);
                  wr_addr <= ADDR_W'(elem_cnt);
                  wr_data <= rx_data;
                  tmo_cnt <= '0;
                  if (elem_last) begin
                     load_done <= 1'b1;
                     state     <= IDLE;
                     busy      <= 1'b0;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  // counter is left saturated; next command clears it
                  abort <= 1'b1;
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
